biquad_cascade_sched: RTL and testbench
=======================================

Name: biquad_cascade_sched

Overview:
- Time-multiplexes one 16x16 multiply-accumulate datapath across NUM_STAGES cascaded biquad sections (parametric EQ bands) for each audio sample.
- Stores per-stage filter history. Holds a double-buffered coefficient bank: the host writes a shadow copy, which is swapped into the active copy only at a sample boundary.
- Sits between the audio sample source (ADC/I2S receiver side) and the output sink.

Parameters:
- NUM_STAGES, 4, number of cascaded biquad sections (1..8).
- ACC_W, 40, accumulator width in bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  16  signed input sample.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  block can accept a sample this cycle.
- sample_out  out  16  signed filtered sample, held until the next result.
- out_valid  out  1  one-cycle pulse when sample_out updates.
- coef_we  in  1  write enable for the shadow coefficient bank.
- coef_addr  in  6  address = stage*5 + idx, where idx 0..4 = b0, b1, b2, a1, a2.
- coef_wdata  in  16  signed Q2.14 coefficient.
- coef_commit  in  1  request a shadow-to-active swap.
- busy  out  1  FSM is not IDLE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE; sample_ready=1; out_valid=0; busy=0; sample_out=0.
  - All per-stage history (x1, x2, y1, y2) = 0; commit_pending=0.
  - Active and shadow banks = passthrough (b0=16'h4000, others 0).
- Arithmetic per stage:
  - acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, using signed ACC_W accumulation.
  - y = sat16(acc >>> 14), saturating to [-32768, 32767].
  - Feedback history stores the saturated 16-bit y.
  - The y of stage s is the x of stage s+1. The last stage's y goes to sample_out.
- FSM states: IDLE, MAC, STORE, DONE.
  - IDLE: sample_ready=1. On sample_valid, latch sample_in and go to MAC with stage=0, idx=0.
  - MAC: one product per cycle, idx 0..4. Acc clears at idx 0. After idx 4, go to STORE.
  - STORE: saturate, then shift history (x2<=x1, x1<=x, y2<=y1, y1<=y). If stage<NUM_STAGES-1: stage++, go to MAC. Else register sample_out and go to DONE.
  - DONE: out_valid=1 for exactly this cycle; sample_ready=0. Next state is IDLE.
- Latency and throughput:
  - If the accept edge is cycle 0, out_valid is high in cycle 6*NUM_STAGES+1 (cycle 25 at the default of 4).
  - Maximum throughput is one sample per 6*NUM_STAGES+2 cycles.
  - sample_valid outside IDLE is ignored. There is no buffering; the upstream holds the sample until ready.
- Coefficients:
  - coef_we writes the shadow bank in any state. coef_addr >= 5*NUM_STAGES is ignored.
  - coef_commit sets commit_pending in any state.
  - The swap (active <= shadow, pending cleared) occurs on an edge where the FSM is IDLE and (commit_pending | coef_commit).
  - A sample accepted on the same edge as a swap uses the new bank.
  - A write and a commit in the same cycle: the write is included in the swap.
  - The active bank never changes between the accept edge and DONE.
  - History is not cleared on a swap.
- Reset mid-operation: aborts the current computation; no out_valid is produced; all reset values apply on the next cycle, including the coefficient banks.

Decomposition:
- Shared package biquad_pkg contains:
  - coefficient index enum (B0, B1, B2, A1, A2);
  - COEF_FRAC=14 and COEF_ONE=16'h4000;
  - the FSM state typedef;
  - a sat16 function.
- One sub-module, biquad_mac:
  - registered signed 16x16 product accumulated into ACC_W;
  - inputs clear, en, sub, a, b; output acc.

Test Plan:
- Passthrough after reset: feed 1234, then -5000 -> sample_out 1234, then -5000. out_valid is exactly 25 cycles after each accept, and sample_ready is low throughout.
- Stage-0 IIR with other stages passthrough: b0=16'h4000, a1=16'hE000 (-0.5), commit, then impulse 1000,0,0 -> outputs 1000, 500, 250.
- Saturation: stage 0 b0=16'h7FFF, inputs 30000 then -30000 -> 32767 then -32768.
- Deferred commit: write stage-0 b0=16'h2000 and pulse coef_commit during MAC of a sample of 800 -> that sample outputs 800; the next sample of 800 outputs 400.
- Handshake: sample_valid held high continuously with values 1, 2, 3 -> exactly three accepts spaced 26 cycles apart; outputs 1, 2, 3; no dropped or duplicated out_valid.
- Reset mid-operation: assert reset at cycle 10 of a computation -> no out_valid; sample_ready=1 and sample_out=0 next cycle; subsequent sample passes through unchanged.

Source files
------------

// File: rtl/biquad_pkg.sv
// Shared types, constants and saturation helper for the biquad cascade scheduler.
package biquad_pkg;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_idx_t;

    localparam int          COEF_FRAC  = 14;
    localparam logic [15:0] COEF_ONE   = 16'h4000;
    localparam int          MAX_STAGES = 8;
    localparam int          MAX_COEF   = MAX_STAGES * 5;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_MAC   = 2'd1;
    localparam state_t ST_STORE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767)
            return 16'sh7FFF;
        else if (v < -64'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// Signed 16x16 multiply folded into an ACC_W accumulator register; one product per enabled cycle.
module biquad_mac #(
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    sub,
    input  logic signed [15:0]      a,
    input  logic signed [15:0]      b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] term;

    always_comb begin
        prod = a * b;
        term = {{(ACC_W-32){prod[31]}}, prod};
        if (sub)
            term = -term;
    end

    // clear restarts the sum with the current product rather than zero
    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (en)
            acc <= (clear ? '0 : acc) + term;
    end

endmodule

// File: rtl/biquad_cascade_sched.sv
// Runs NUM_STAGES biquad sections through one shared MAC, 6 cycles per stage, with a
// shadow/active coefficient bank swapped only while idle so a sample never sees a mixed bank.
module biquad_cascade_sched
    import biquad_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int ACC_W      = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [15:0] sample_out,
    output logic        out_valid,
    input  logic        coef_we,
    input  logic [5:0]  coef_addr,
    input  logic [15:0] coef_wdata,
    input  logic        coef_commit,
    output logic        busy
);

    localparam int NCOEF = 5 * NUM_STAGES;

    state_t state;
    logic [2:0] stage;
    logic [2:0] idx;
    logic signed [15:0] cur_x;

    logic signed [15:0] x1 [MAX_STAGES];
    logic signed [15:0] x2 [MAX_STAGES];
    logic signed [15:0] y1 [MAX_STAGES];
    logic signed [15:0] y2 [MAX_STAGES];

    logic [15:0] active     [MAX_COEF];
    logic [15:0] shadow     [MAX_COEF];
    logic [15:0] shadow_nxt [MAX_COEF];
    logic        commit_pending;
    logic        swap;

    logic [5:0]              caddr;
    logic signed [15:0]      mac_a;
    logic signed [15:0]      mac_b;
    logic                    mac_sub;
    logic signed [ACC_W-1:0] acc;
    logic signed [63:0]      acc_ext;
    logic signed [15:0]      y_sat;

    assign sample_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign out_valid    = (state == ST_DONE);

    // A same-cycle write lands in the bank that gets swapped in
    always_comb begin
        shadow_nxt = shadow;
        if (coef_we && (coef_addr < 6'(NCOEF)))
            shadow_nxt[coef_addr] = coef_wdata;
    end

    assign swap = (state == ST_IDLE) && (commit_pending || coef_commit);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_COEF; i++) begin
                active[i] <= (i % 5 == 0) ? COEF_ONE : 16'h0000;
                shadow[i] <= (i % 5 == 0) ? COEF_ONE : 16'h0000;
            end
            commit_pending <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (swap) begin
                active         <= shadow_nxt;
                commit_pending <= 1'b0;
            end else if (coef_commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        caddr   = 6'(stage) * 6'd5 + 6'(idx);
        mac_a   = active[caddr];
        mac_sub = (idx >= 3'(A1));
        case (idx)
            B0:      mac_b = cur_x;
            B1:      mac_b = x1[stage];
            B2:      mac_b = x2[stage];
            A1:      mac_b = y1[stage];
            default: mac_b = y2[stage];
        endcase
    end

    biquad_mac #(.ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (idx == 3'(B0)),
        .en    (state == ST_MAC),
        .sub   (mac_sub),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (acc)
    );

    always_comb begin
        acc_ext = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
        y_sat   = sat16(acc_ext >>> COEF_FRAC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            stage      <= '0;
            idx        <= '0;
            cur_x      <= '0;
            sample_out <= '0;
            for (int i = 0; i < MAX_STAGES; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        cur_x <= sample_in;
                        stage <= '0;
                        idx   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (idx == 3'(A2)) begin
                        idx   <= '0;
                        state <= ST_STORE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_STORE: begin
                    x2[stage] <= x1[stage];
                    x1[stage] <= cur_x;
                    y2[stage] <= y1[stage];
                    y1[stage] <= y_sat;
                    // this stage's output is the next stage's input
                    cur_x     <= y_sat;
                    if (stage == 3'(NUM_STAGES - 1)) begin
                        sample_out <= y_sat;
                        state      <= ST_DONE;
                    end else begin
                        stage <= stage + 3'd1;
                        state <= ST_MAC;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_cascade_sched.sv
// Bench for biquad_cascade_sched: cycle-level reference model plus directed and random stimulus.
module tb_biquad_cascade_sched;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] sample_out;
    logic        out_valid;
    logic        coef_we;
    logic [5:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        coef_commit;
    logic        busy;

    always #5 clk = ~clk;

    biquad_cascade_sched #(.NUM_STAGES(NS), .ACC_W(40)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .coef_commit  (coef_commit),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 0;

    // Reference model state
    int m_act [5*NS];
    int m_sh  [5*NS];
    int m_x1 [NS], m_x2 [NS], m_y1 [NS], m_y2 [NS];
    bit m_pend;
    int phase;
    int m_res;
    int m_out;

    int got_q[$];
    int acc_cyc_q[$];
    int val_cyc_q[$];

    function automatic int sat(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 5*NS; i++) begin
            m_act[i] = (i % 5 == 0) ? 16384 : 0;
            m_sh[i]  = m_act[i];
        end
        for (int s = 0; s < NS; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        m_pend = 0;
        phase  = -1;
        m_res  = 0;
        m_out  = 0;
    endfunction

    function automatic int m_filter(int x_in);
        int x = x_in;
        int y;
        longint acc;
        for (int s = 0; s < NS; s++) begin
            acc = longint'(m_act[s*5+0]) * x + longint'(m_act[s*5+1]) * m_x1[s]
                + longint'(m_act[s*5+2]) * m_x2[s] - longint'(m_act[s*5+3]) * m_y1[s]
                - longint'(m_act[s*5+4]) * m_y2[s];
            y = sat(acc >>> 14);
            m_x2[s] = m_x1[s]; m_x1[s] = x;
            m_y2[s] = m_y1[s]; m_y1[s] = y;
            x = y;
        end
        return x;
    endfunction

    // phase = cycles since the accept cycle; -1 while idle, DONE is phase 25
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_reset();
        end else begin
            if (coef_we && coef_addr < 6'(5*NS))
                m_sh[coef_addr] = int'($signed(coef_wdata));
            if (coef_commit)
                m_pend = 1;
            if (phase < 0) begin
                if (m_pend) begin
                    m_act  = m_sh;
                    m_pend = 0;
                end
                if (sample_valid) begin
                    m_res = m_filter(int'($signed(sample_in)));
                    phase = 1;
                end
            end else begin
                phase++;
                if (phase == 25) m_out = m_res;
                if (phase == 26) phase = -1;
            end
        end
    end

    task automatic chk(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("ready", int'(sample_ready), int'(phase < 0));
            chk("busy", int'(busy), int'(phase >= 0));
            chk("out_valid", int'(out_valid), int'(phase == 25));
            chk("sample_out", int'($signed(sample_out)), m_out);
            if (out_valid) begin
                got_q.push_back(int'($signed(sample_out)));
                val_cyc_q.push_back(cyc);
            end
            if (sample_valid && sample_ready && !reset)
                acc_cyc_q.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        coef_we = 1'b0;
        coef_commit = 1'b0;
        step();
        reset = 1'b0;
        got_q.delete();
        acc_cyc_q.delete();
        val_cyc_q.delete();
    endtask

    task automatic wcoef(int addr, logic [15:0] d);
        coef_we = 1'b1;
        coef_addr = 6'(addr);
        coef_wdata = d;
        step();
        coef_we = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        step();
        coef_commit = 1'b0;
    endtask

    task automatic send(int v);
        int g = 0;
        sample_valid = 1'b1;
        sample_in = 16'(v);
        while (!sample_ready && g < 100) begin step(); g++; end
        if (!sample_ready) begin
            total++; bad++;
            $display("FAIL send: sample_ready never rose");
        end
        step();
        sample_valid = 1'b0;
    endtask

    task automatic expect_out(string nm, int v);
        int g = 0;
        while (got_q.size() == 0 && g < 80) begin step(); g++; end
        if (got_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: no out_valid within 80 cycles, expected=%0d", nm, v);
        end else begin
            chk(nm, got_q.pop_front(), v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pending_acc;
        reset = 1'b1;
        sample_in = '0;
        sample_valid = 1'b0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_wdata = '0;
        coef_commit = 1'b0;
        step();
        armed = 1;
        step();
        do_reset();

        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sample_out", int'($signed(sample_out)), 0);

        // Passthrough with exact latency
        send(1234);
        expect_out("pass_1234", 1234);
        send(-5000);
        expect_out("pass_m5000", -5000);
        for (int i = 0; i < 2; i++)
            if (acc_cyc_q.size() > i && val_cyc_q.size() > i)
                chk("pass_latency", val_cyc_q[i] - acc_cyc_q[i], 25);
            else begin
                total++; bad++;
                $display("FAIL pass_latency: missing accept/valid record %0d", i);
            end

        // Stage-0 one-pole IIR, a1 = -0.5
        do_reset();
        wcoef(3, 16'hE000);
        commit();
        send(1000);
        expect_out("iir_0", 1000);
        send(0);
        expect_out("iir_1", 500);
        send(0);
        expect_out("iir_2", 250);

        // Saturation in stage 0
        do_reset();
        wcoef(0, 16'h7FFF);
        commit();
        send(30000);
        expect_out("sat_pos", 32767);
        send(-30000);
        expect_out("sat_neg", -32768);

        // Write+commit mid-computation is deferred to the next sample
        do_reset();
        sample_valid = 1'b1;
        sample_in = 16'd800;
        step();
        sample_valid = 1'b0;
        repeat (3) step();
        coef_we = 1'b1;
        coef_addr = 6'd0;
        coef_wdata = 16'h2000;
        coef_commit = 1'b1;
        step();
        coef_we = 1'b0;
        coef_commit = 1'b0;
        expect_out("defer_old", 800);
        send(800);
        expect_out("defer_new", 400);

        // Continuous sample_valid
        do_reset();
        sample_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            int g = 0;
            sample_in = 16'(v);
            while (!sample_ready && g < 100) begin step(); g++; end
            step();
        end
        sample_valid = 1'b0;
        expect_out("hs_1", 1);
        expect_out("hs_2", 2);
        expect_out("hs_3", 3);
        repeat (30) step();
        chk("hs_accepts", acc_cyc_q.size(), 3);
        chk("hs_no_extra_valid", got_q.size(), 0);
        if (acc_cyc_q.size() >= 3) begin
            chk("hs_space_12", acc_cyc_q[1] - acc_cyc_q[0], 26);
            chk("hs_space_23", acc_cyc_q[2] - acc_cyc_q[1], 26);
        end

        // Reset mid-computation
        do_reset();
        sample_valid = 1'b1;
        sample_in = 16'd555;
        step();
        sample_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_ready", int'(sample_ready), 1);
        chk("midrst_sample_out", int'($signed(sample_out)), 0);
        repeat (30) step();
        chk("midrst_no_valid", got_q.size(), 0);
        send(777);
        expect_out("midrst_after", 777);

        // Randomized traffic, coefficient updates and commits
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            pending_acc = int'(sample_valid && sample_ready);
            coef_we = ($urandom % 8 == 0);
            coef_addr = ($urandom % 4 == 0) ? 6'($urandom % 64) : 6'($urandom % 20);
            coef_wdata = ($urandom % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16384) - 8192);
            coef_commit = ($urandom % 16 == 0);
            if (!sample_valid && $urandom % 3 == 0) begin
                sample_valid = 1'b1;
                sample_in = ($urandom % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
            end
            reset = ($urandom % 1500 == 0);
            step();
            if (pending_acc != 0 || reset)
                sample_valid = 1'b0;
            reset = 1'b0;
        end
        coef_we = 1'b0;
        coef_commit = 1'b0;
        sample_valid = 1'b0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
